// File: rtl/xadc_drp_scheduler_if.sv
// DRP bus between the access scheduler (master) and the XADC Wizard (slave).
interface xadc_drp_scheduler_if;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;

  modport master (
    output drp_daddr,
    output drp_den,
    output drp_dwe,
    output drp_di,
    input  drp_do,
    input  drp_drdy
  );

  modport slave (
    input  drp_daddr,
    input  drp_den,
    input  drp_dwe,
    input  drp_di,
    output drp_do,
    output drp_drdy
  );
endinterface

// File: rtl/xadc_drp_scheduler.sv
// Shares the XADC DRP port between NUM_REQ register requesters and an
// EOC-triggered auto-read. One access outstanding at a time; each access is a
// single-cycle DEN strobe followed by a DRDY wait with timeout recovery.
module xadc_drp_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [6:0]  AUTO_ADDR      = 7'h1F
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    eoc_in,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [7*NUM_REQ-1:0]    req_addr,
  input  logic [16*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [15:0]             rsp_data,
  output logic                    rsp_timeout,
  output logic                    sample_valid,
  output logic [15:0]             sample_data,
  output logic                    eoc_overrun,
  xadc_drp_scheduler_if.master    drp
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            eoc_pend;
  logic [PW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;
  logic            cur_auto;
  logic [PW-1:0]   cur_idx;

  logic            grant_hit;
  logic [PW-1:0]   grant_idx;
  logic            grant_auto;
  logic            grant_req;
  logic            done_ok;
  logic            done_tmo;

  // Round-robin search over req_valid starting at rr_ptr, wrapping.
  always_comb begin
    int unsigned cand;
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_REQ;
      if (!grant_hit && req_valid[cand[PW-1:0]]) begin
        grant_hit = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> ISSUE (one cycle) -> WAIT -> IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (eoc_pend || grant_hit) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (drp.drp_drdy || (cnt == CNT_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decode of grant/completion events; auto-read beats every requester.
  always_comb begin
    grant_auto = (state == IDLE) && eoc_pend;
    grant_req  = (state == IDLE) && !eoc_pend && grant_hit;
    done_ok    = (state == WAIT) && drp.drp_drdy;
    done_tmo   = (state == WAIT) && !drp.drp_drdy && (cnt == CNT_LAST);
  end

  // EOC latch: a clear and a new EOC in the same cycle keep the request pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eoc_pend    <= 1'b0;
      eoc_overrun <= 1'b0;
    end else begin
      eoc_pend    <= eoc_in | (eoc_pend & ~grant_auto);
      eoc_overrun <= eoc_in & eoc_pend & ~grant_auto;
    end
  end

  // WAIT-cycle counter, zero outside WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (state == WAIT)  cnt <= cnt + 1'b1;
    else                     cnt <= '0;
  end

  // Registered DRP drive, accept pulses and completion reporting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drp.drp_daddr <= '0;
      drp.drp_den   <= 1'b0;
      drp.drp_dwe   <= 1'b0;
      drp.drp_di    <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      rsp_timeout   <= 1'b0;
      sample_valid  <= 1'b0;
      sample_data   <= '0;
      rr_ptr        <= '0;
      cur_auto      <= 1'b0;
      cur_idx       <= '0;
    end else begin
      drp.drp_den  <= 1'b0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_timeout  <= 1'b0;
      sample_valid <= 1'b0;

      if (grant_auto) begin
        drp.drp_den   <= 1'b1;
        drp.drp_daddr <= AUTO_ADDR;
        drp.drp_dwe   <= 1'b0;
        drp.drp_di    <= '0;
        cur_auto      <= 1'b1;
      end else if (grant_req) begin
        drp.drp_den   <= 1'b1;
        drp.drp_daddr <= req_addr[grant_idx*7 +: 7];
        drp.drp_dwe   <= req_write[grant_idx];
        drp.drp_di    <= req_write[grant_idx] ? req_wdata[grant_idx*16 +: 16] : '0;
        cur_auto      <= 1'b0;
        cur_idx       <= grant_idx;
        req_ready     <= NUM_REQ'(1) << grant_idx;
        rr_ptr        <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end

      if (done_ok || done_tmo) begin
        rsp_timeout <= done_tmo;
        if (cur_auto) begin
          sample_valid <= 1'b1;
          if (done_ok) sample_data <= drp.drp_do;
        end else begin
          rsp_valid <= NUM_REQ'(1) << cur_idx;
          rsp_data  <= done_ok ? drp.drp_do : '0;
        end
      end
    end
  end

endmodule
